awb_gain_ctrl: RTL and testbench

AWB_GAIN_CTRL -- requirements
Module: awb_gain_ctrl

---
 rtl/awb_gain_ctrl.sv | 179 +++++++++++++++++
 tb/tb_awb_gain_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/awb_gain_ctrl.sv
// rtl/awb_gain_ctrl.sv - auto white balance gain controller (channel sums, serial divide, atomic gain update)
module awb_gain_ctrl #(
    parameter int SUM_W    = 28,
    parameter int GR_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [1:0]  color_i,
    input  logic [7:0]  value_i,
    input  logic        last_i,
    input  logic        hold_i,
    output logic [15:0] K_R,
    output logic [15:0] K_G,
    output logic [15:0] K_B,
    output logic        valid_gain_o,
    output logic        busy_o,
    output logic        frame_drop_o
);

    localparam int QW = SUM_W + 8;
    localparam int DW = SUM_W + GR_SHIFT;
    localparam int RW = DW + 1;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
    localparam logic [QW-1:0] Q_MAX    = QW'(16'h0FFF);

    typedef enum logic [1:0] {ACC, DIV_R, DIV_B, UPDATE} state_t;
    state_t state, state_nx;

    logic [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic [SUM_W-1:0] add_r, add_g, add_b;
    logic [SUM_W-1:0] snap_r, snap_g, snap_b;
    logic             frame_end;

    logic [QW-1:0]    num_sr, quo, q_fin;
    logic [RW-1:0]    rem, trial, den_ext;
    logic [SUM_W-1:0] den_src;
    logic [CW-1:0]    cnt;
    logic             q_bit, div_last;
    logic [15:0]      q_sat, kr_pend, kb_pend;

    logic             busy_nx, drop_nx, update_en;

    assign frame_end = valid_i & last_i;

    always_comb begin
        add_r = sum_r + ((valid_i && color_i == 2'd0) ? SUM_W'(value_i) : '0);
        add_g = sum_g + ((valid_i && color_i == 2'd1) ? SUM_W'(value_i) : '0);
        add_b = sum_b + ((valid_i && color_i == 2'd2) ? SUM_W'(value_i) : '0);
    end

    // Every frame end clears the sums, whether the frame is kept or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (frame_end) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else begin
            sum_r <= add_r;
            sum_g <= add_g;
            sum_b <= add_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_r <= '0;
            snap_g <= '0;
            snap_b <= '0;
        end else if (frame_end && state == ACC) begin
            snap_r <= add_r;
            snap_g <= add_g;
            snap_b <= add_b;
        end
    end

    // One restoring step per edge; red and blue share the datapath.
    always_comb begin
        den_src  = (state == DIV_B) ? snap_b : snap_r;
        den_ext  = RW'(den_src) << GR_SHIFT;
        trial    = {rem[RW-2:0], num_sr[QW-1]};
        q_bit    = (trial >= den_ext);
        q_fin    = {quo[QW-2:0], q_bit};
        q_sat    = (den_src == '0 || q_fin > Q_MAX) ? 16'h0FFF : q_fin[15:0];
        div_last = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_sr  <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            kr_pend <= '0;
            kb_pend <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (frame_end) begin
                        num_sr <= {add_g, 8'd0};
                        quo    <= '0;
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                DIV_R, DIV_B: begin
                    if (div_last) begin
                        if (state == DIV_R) begin
                            kr_pend <= q_sat;
                        end else begin
                            kb_pend <= q_sat;
                        end
                        num_sr <= {snap_g, 8'd0};
                        quo    <= '0;
                        rem    <= '0;
                        cnt    <= '0;
                    end else begin
                        num_sr <= num_sr << 1;
                        quo    <= q_fin;
                        rem    <= q_bit ? (trial - den_ext) : trial;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACC:     if (frame_end) state_nx = DIV_R;
            DIV_R:   if (div_last)  state_nx = DIV_B;
            DIV_B:   if (div_last)  state_nx = UPDATE;
            UPDATE:  state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        busy_nx   = (state_nx != ACC);
        drop_nx   = frame_end && (state != ACC);
        update_en = (state == UPDATE) && !hold_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            K_R          <= 16'h0100;
            K_G          <= 16'h0100;
            K_B          <= 16'h0100;
            valid_gain_o <= 1'b0;
            busy_o       <= 1'b0;
            frame_drop_o <= 1'b0;
        end else begin
            busy_o       <= busy_nx;
            frame_drop_o <= drop_nx;
            if (update_en) begin
                K_R          <= kr_pend;
                K_G          <= 16'h0100;
                K_B          <= kb_pend;
                valid_gain_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// tb/tb_awb_gain_ctrl.sv - self-checking bench for awb_gain_ctrl
module tb_awb_gain_ctrl;

    localparam int GR       = 1;
    localparam int UPD_EDGE = 73;

    logic        clk = 1'b0;
    bit          clk_en = 1'b0;
    logic        rst;
    logic        valid_i, last_i, hold_i;
    logic [1:0]  color_i;
    logic [7:0]  value_i;
    logic [15:0] K_R, K_G, K_B;
    logic        valid_gain_o, busy_o, frame_drop_o;

    int checks = 0;
    int failures = 0;

    longint      mr, mg, mb;
    logic [15:0] pend_kr, pend_kb, exp_kr, exp_kg, exp_kb;
    bit          exp_valid, dividing;
    int          edge_n;

    awb_gain_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .color_i      (color_i),
        .value_i      (value_i),
        .last_i       (last_i),
        .hold_i       (hold_i),
        .K_R          (K_R),
        .K_G          (K_G),
        .K_B          (K_B),
        .valid_gain_o (valid_gain_o),
        .busy_o       (busy_o),
        .frame_drop_o (frame_drop_o)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Gain = 256*G / (R * 2^GR), capped at 0x0FFF; zero denominator also caps.
    function automatic logic [15:0] gain(input longint g, input longint r);
        longint den, q;
        den = r << GR;
        if (den == 0) return 16'h0FFF;
        q = (g * 256) / den;
        if (q > 4095) return 16'h0FFF;
        return q[15:0];
    endfunction

    task automatic model_reset();
        mr = 0; mg = 0; mb = 0;
        exp_kr = 16'h0100; exp_kg = 16'h0100; exp_kb = 16'h0100;
        exp_valid = 1'b0;
        dividing = 1'b0;
        edge_n = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        edge_n++;
    endtask

    task automatic send(input int c, input int v, input bit l);
        valid_i = 1'b1;
        color_i = c[1:0];
        value_i = v[7:0];
        last_i  = l;
        if (c == 0) mr += v;
        if (c == 1) mg += v;
        if (c == 2) mb += v;
        if (l) begin
            if (!dividing) begin
                pend_kr  = gain(mg, mr);
                pend_kb  = gain(mg, mb);
                dividing = 1'b1;
                edge_n   = -1;
            end
            mr = 0; mg = 0; mb = 0;
        end
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic finish_frame();
        while (edge_n < UPD_EDGE) begin
            chk("busy_during_div", busy_o, 1);
            chk("kr_stable_during_div", K_R, exp_kr);
            tick();
        end
        dividing = 1'b0;
        if (!hold_i) begin
            exp_kr = pend_kr;
            exp_kb = pend_kb;
            exp_kg = 16'h0100;
            exp_valid = 1'b1;
        end
        chk("busy_after_update", busy_o, 0);
        chk("K_R", K_R, exp_kr);
        chk("K_G", K_G, exp_kg);
        chk("K_B", K_B, exp_kb);
        chk("valid_gain", valid_gain_o, exp_valid);
        chk("frame_drop_idle", frame_drop_o, 0);
    endtask

    task automatic rand_frame(input int n);
        for (int i = 0; i < n; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 255), i == n - 1);
        end
    endtask

    task automatic nominal_frame();
        send(0, 64, 0);
        send(1, 128, 0);
        send(1, 128, 0);
        send(2, 32, 1);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; last_i = 1'b0; hold_i = 1'b0;
        color_i = 2'd0; value_i = 8'd0;
        model_reset();

        // Reset with the clock stopped
        #20;
        chk("rst_K_R", K_R, 16'h0100);
        chk("rst_K_G", K_G, 16'h0100);
        chk("rst_K_B", K_B, 16'h0100);
        chk("rst_valid", valid_gain_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_drop", frame_drop_o, 0);

        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy_o, 0);

        // Nominal frame
        nominal_frame();
        chk("busy_edge0", busy_o, 1);
        finish_frame();
        chk("nominal_K_R_const", K_R, 16'h0200);
        chk("nominal_K_B_const", K_B, 16'h0400);

        // R = 0
        send(1, 10, 0);
        send(2, 5, 0);
        send(1, 20, 1);
        finish_frame();
        chk("r_zero_const", K_R, 16'h0FFF);

        // R = 1 with large green saturates
        send(0, 1, 0);
        send(1, 255, 0);
        send(1, 255, 0);
        send(2, 200, 1);
        finish_frame();
        chk("r_one_sat_const", K_R, 16'h0FFF);

        // Back-to-back: second last 10 cycles after the first is dropped
        nominal_frame();
        for (int i = 0; i < 10; i++) begin
            send($urandom_range(0, 2), $urandom_range(0, 255), i == 9);
        end
        chk("drop_pulse", frame_drop_o, 1);
        tick();
        chk("drop_one_cycle", frame_drop_o, 0);
        finish_frame();
        rand_frame(12);
        finish_frame();

        // Hold through UPDATE, then release
        hold_i = 1'b1;
        send(0, 10, 0);
        send(1, 90, 0);
        send(2, 40, 1);
        finish_frame();
        hold_i = 1'b0;
        rand_frame(16);
        finish_frame();

        // Reset mid-division
        nominal_frame();
        while (edge_n < 39) tick();
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_K_R", K_R, 16'h0100);
        chk("midrst_K_G", K_G, 16'h0100);
        chk("midrst_K_B", K_B, 16'h0100);
        chk("midrst_valid", valid_gain_o, 0);
        chk("midrst_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("postrst_busy", busy_o, 0);
        send(0, 50, 0);
        send(1, 100, 0);
        send(3, 77, 0);
        send(1, 100, 0);
        send(2, 25, 1);
        finish_frame();

        // Frame ended by an ignored-channel sample
        send(0, 30, 0);
        send(1, 70, 0);
        send(2, 60, 0);
        send(3, 255, 1);
        finish_frame();

        // Random frames with occasional hold
        for (int f = 0; f < 5; f++) begin
            hold_i = ($urandom_range(0, 3) == 0);
            rand_frame($urandom_range(4, 24));
            finish_frame();
            hold_i = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
